intercon_cfg_loader: RTL
========================

// Module: intercon_cfg_loader
// PURPOSE
//  Sequences the serial configuration chain of NUM_XBARS daisy-chained 20-switch interconnect
//  crossbars. Accepts one 20-bit switch word per crossbar over a valid/ready port.
//  Generates shift_clk/shift_en/shift_i toward the chain head.
//  Sits between the fabric config controller and the general-purpose interconnect row.
// PARAMETERS
//  NUM_XBARS  4   crossbars in the chain (>=1); words per load
//  XBAR_BITS  20  switch bits per crossbar (fixed by crossbar pin map)
//  CLK_DIV    2   clk cycles per shift_clk half-period (>=1)
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst         in   1   synchronous active-high reset
//  start       in   1   1-cycle pulse: begin a full-chain load (ignored unless IDLE)
//  abort       in   1   level: terminate load, return to IDLE
//  cfg_valid   in   1   cfg_data valid
//  cfg_ready   out  1   loader accepts word this cycle
//  cfg_data    in   XBAR_BITS  switch word; bit0 shifted first
//  busy        out  1   high from start accept until return to IDLE
//  done        out  1   1-cycle pulse: all NUM_XBARS*XBAR_BITS bits shifted
//  aborted     out  1   1-cycle pulse: load ended by abort
//  shift_clk   out  1   chain shift clock; chain samples shift_i on rising edge
//  shift_en    out  1   chain shift enable; high for entire load
//  shift_i     out  1   serial data into chain head
//  shift_o     in   1   serial data out of chain tail
// BEHAVIOUR
//  Reset: state=IDLE; cfg_ready, busy, done, aborted, shift_clk, shift_en, shift_i = 0.
//  Reset mid-load does the same next edge; chain contents then undefined, no done/aborted.
//  States: IDLE -> WAIT_WORD -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | WAIT_WORD | DONE) -> IDLE.
//  IDLE: start=1 -> WAIT_WORD next cycle; busy=1, shift_en=1, word_cnt=0. cfg_valid ignored.
//  WAIT_WORD: cfg_ready=1 (registered). On cfg_valid&cfg_ready, latch cfg_data and bit_cnt=0.
//    Then go to SHIFT_LO. cfg_ready drops the following cycle.
//  SHIFT_LO: shift_clk=0, shift_i=word[bit_cnt], held CLK_DIV cycles, then SHIFT_HI.
//  SHIFT_HI: shift_clk=1 for CLK_DIV cycles; shift_i stable (setup >= CLK_DIV clk).
//    Exit: bit_cnt<XBAR_BITS-1 -> bit_cnt++, SHIFT_LO.
//    Else word_cnt<NUM_XBARS-1 -> word_cnt++, WAIT_WORD (shift_clk returns 0).
//    Else DONE.
//  DONE: 1 cycle; done=1, shift_clk=0, shift_en=0, busy=0 next cycle, -> IDLE.
//  Ordering: word 0 lands in the crossbar farthest from the head (index NUM_XBARS-1).
//  Per-word shift time = 2*CLK_DIV*XBAR_BITS clk cycles. Exactly XBAR_BITS rising edges per word.
//  shift_clk is low whenever state != SHIFT_HI (no partial pulse on any exit).
//  Between words shift_en stays 1; shift_clk idles low; stall length unbounded.
//  abort=1 in any non-IDLE state: next cycle IDLE, aborted=1 one cycle, all outputs to reset values.
//    If abort and start coincide in IDLE, start wins (abort has no effect in IDLE).
//  start while busy: ignored. Counters: bit_cnt $clog2(XBAR_BITS), word_cnt $clog2(NUM_XBARS)+1.
// CONFIGURATION
//  CFG_READBACK_EN defined: extra ports rd_valid(out,1) and rd_data(out,XBAR_BITS).
//    shift_o is sampled on the last clk of each SHIFT_HI, into rd_data[bit_cnt].
//    After the 20th bit of each word, rd_valid=1 for one cycle. rd_data then holds the prior
//    contents displaced from the tail (old config, farthest crossbar first).
//    No backpressure on rd_valid. rd_valid=0 and rd_data=0 on reset.
//  Undefined: ports absent; shift_o unused; no readback logic.
// TESTING
//  T1 reset: rst=1 in SHIFT_HI -> next cycle all outputs 0, state IDLE, no done pulse.
//  T2 load NUM_XBARS=4, CLK_DIV=2, words 20'hA5A5A,20'h00001,20'hFFFFF,20'h12345 -> 80 shift_clk rises.
//    Chain model matches, words in reverse order from head. done 1 cycle, busy low after.
//  T3 cfg_valid withheld 50 cycles after word 1: shift_clk stays low, shift_en stays high.
//    Load completes correctly after resume.
//  T4 abort asserted after 7 bits of word 2 -> aborted pulse, no done, shift_clk never glitches high.
//    A following start/load succeeds.
//  T5 start during busy and cfg_valid in IDLE: both ignored; cfg_ready stays 0 in IDLE.
//  T6 (CFG_READBACK_EN) preload chain with pattern P, load Q -> 4 rd_valid pulses.
//    rd_data equals P words, farthest first; second load returns Q.

Source files
------------

// File: rtl/intercon_cfg_loader.sv
// -----------------------------------------------------------------------------
// intercon_cfg_loader
//
// Purpose:
//   Loads the serial configuration chain of NUM_XBARS daisy-chained crossbars.
//   The fabric config controller hands over one XBAR_BITS-wide switch word per
//   crossbar on a valid/ready port. Each word is shifted toward the chain head
//   LSB first, one bit per shift_clk rising edge. shift_clk is a divided,
//   registered clock: CLK_DIV clk cycles low, then CLK_DIV clk cycles high.
//   The first word accepted ends up in the crossbar farthest from the head.
//
// Handshake:
//   A word moves on any rising clk edge where cfg_valid and cfg_ready are both
//   high. cfg_ready is registered. It is high only in WAIT_WORD, and it drops on
//   the edge that takes the word. The word is held internally while it shifts,
//   so cfg_data may change right after the transfer.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      1-cycle pulse, begins a full-chain load (honoured only in IDLE)
//   abort      level, ends any load in progress and returns to IDLE
//   cfg_valid  cfg_data is valid
//   cfg_ready  loader takes cfg_data this cycle
//   cfg_data   switch word, bit 0 shifted first
//   busy       high from start accept until the return to IDLE
//   done       1-cycle pulse, all NUM_XBARS*XBAR_BITS bits shifted
//   aborted    1-cycle pulse, load ended by abort
//   shift_clk  chain shift clock, the chain samples shift_i on its rising edge
//   shift_en   chain shift enable, high for the entire load
//   shift_i    serial data into the chain head
//   shift_o    serial data out of the chain tail
//   fsm_state  current FSM state (debug/observation)
//
// Optional feature (macro CFG_READBACK_EN):
//   Defining the macro adds the ports rd_valid and rd_data. shift_o is sampled
//   on the last clk of every SHIFT_HI phase. After the final bit of each word,
//   rd_valid pulses for one cycle. rd_data then holds the word displaced from
//   the chain tail, which is the old config, farthest crossbar first.
//   When the macro is undefined, shift_o is unused.
// -----------------------------------------------------------------------------
module intercon_cfg_loader #(
    parameter int NUM_XBARS = 4,
    parameter int XBAR_BITS = 20,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [XBAR_BITS-1:0] cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 shift_clk,
    output logic                 shift_en,
    output logic                 shift_i,
    input  logic                 shift_o,
    output logic [2:0]           fsm_state
`ifdef CFG_READBACK_EN
    ,
    output logic                 rd_valid,
    output logic [XBAR_BITS-1:0] rd_data
`endif
);

    localparam int BIT_W  = (XBAR_BITS > 1) ? $clog2(XBAR_BITS) : 1;
    localparam int WORD_W = $clog2(NUM_XBARS) + 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(XBAR_BITS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_XBARS - 1);
    localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_SHIFT_LO  = 3'd2,
        S_SHIFT_HI  = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                 state;
    logic [XBAR_BITS-1:0]   word;
    logic [BIT_W-1:0]       bit_cnt;
    logic [WORD_W-1:0]      word_cnt;
    logic [DIV_W-1:0]       div_cnt;

    assign fsm_state = state;

`ifndef CFG_READBACK_EN
    logic unused_shift_o;
    assign unused_shift_o = shift_o;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            word      <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            div_cnt   <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            shift_clk <= 1'b0;
            shift_en  <= 1'b0;
            shift_i   <= 1'b0;
`ifdef CFG_READBACK_EN
            rd_valid  <= 1'b0;
            rd_data   <= '0;
`endif
        end else begin
            // Pulses default low. Each one is raised for a single cycle below.
            done    <= 1'b0;
            aborted <= 1'b0;
`ifdef CFG_READBACK_EN
            rd_valid <= 1'b0;
`endif
            if (abort && state != S_IDLE) begin
                // Abort drops shift_clk on the same edge. A high phase may be
                // cut short, but a new rising edge is never issued.
                state     <= S_IDLE;
                cfg_ready <= 1'b0;
                busy      <= 1'b0;
                shift_clk <= 1'b0;
                shift_en  <= 1'b0;
                shift_i   <= 1'b0;
                aborted   <= 1'b1;
`ifdef CFG_READBACK_EN
                rd_data   <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_WAIT_WORD;
                            busy      <= 1'b1;
                            shift_en  <= 1'b1;
                            cfg_ready <= 1'b1;
                            word_cnt  <= '0;
                        end
                    end

                    S_WAIT_WORD: begin
                        if (cfg_valid && cfg_ready) begin
                            word      <= cfg_data;
                            bit_cnt   <= '0;
                            div_cnt   <= '0;
                            shift_i   <= cfg_data[0];
                            cfg_ready <= 1'b0;
                            state     <= S_SHIFT_LO;
                        end
                    end

                    S_SHIFT_LO: begin
                        // shift_i has been stable since this phase began.
                        // That gives CLK_DIV cycles of setup before the rise.
                        if (div_cnt == LAST_DIV) begin
                            div_cnt   <= '0;
                            shift_clk <= 1'b1;
                            state     <= S_SHIFT_HI;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end

                    S_SHIFT_HI: begin
                        if (div_cnt == LAST_DIV) begin
                            div_cnt   <= '0;
                            shift_clk <= 1'b0;
`ifdef CFG_READBACK_EN
                            // The tail still presents the bit pushed out by this
                            // rising edge.
                            rd_data[bit_cnt] <= shift_o;
`endif
                            if (bit_cnt != LAST_BIT) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shift_i <= word[bit_cnt + 1'b1];
                                state   <= S_SHIFT_LO;
                            end else begin
`ifdef CFG_READBACK_EN
                                rd_valid <= 1'b1;
`endif
                                if (word_cnt != LAST_WORD) begin
                                    word_cnt  <= word_cnt + 1'b1;
                                    cfg_ready <= 1'b1;
                                    state     <= S_WAIT_WORD;
                                end else begin
                                    done     <= 1'b1;
                                    shift_en <= 1'b0;
                                    shift_i  <= 1'b0;
                                    state    <= S_DONE;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        // busy is held through DONE and falls with the return
                        // to IDLE.
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
